lut_sweep: RTL and testbench
============================

LUT_SWEEP -- requirements
Module: lut_sweep

Interface
REQ-001 SHALL have parameter W, default 4, meaning input/output word width; legal range 2..8.
REQ-002 SHALL have parameter DEPTH, fixed at 2**W, meaning the number of table entries (derived, not overridable).
REQ-003 SHALL have one clock, reset synchronous active-high: clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 wr_en  input  1  table write strobe.
REQ-006 wr_addr  input  W  table entry written.
REQ-007 wr_data  input  W  value stored at wr_addr.
REQ-008 in_valid  input  1  lookup request present.
REQ-009 in_data  input  W  lookup address.
REQ-010 in_ready  output  1  lookup request accepted this cycle.
REQ-011 out_valid  output  1  result present.
REQ-012 out_data  output  W  table[address].
REQ-013 out_addr  output  W  address that produced out_data.
REQ-014 out_ready  input  1  consumer accepts result.
REQ-015 sweep_start  input  1  start automatic sweep of all entries.
REQ-016 busy  output  1  sweep in progress.
REQ-017 done  output  1  one-cycle pulse at sweep completion.

Function
REQ-018 Table SHALL be DEPTH x W registers; a write occurs at the clk edge when wr_en=1, in any state.
REQ-019 Output stage SHALL be a single register slot; the slot is free when out_valid=0 or out_ready=1.
REQ-020 In IDLE: in_ready = slot free; a handshake (in_valid & in_ready) loads out_data=table[in_data] and out_addr=in_data, with out_valid=1 on the next cycle (latency 1).
REQ-021 With out_valid=1 and out_ready=0, out_data/out_addr/out_valid SHALL hold stable.
REQ-022 Same-cycle write and lookup of the same address SHALL return the pre-write value.
REQ-023 FSM states: IDLE, SWEEP, DONE; encodings are held in the shared package.
REQ-024 IDLE->SWEEP when sweep_start=1; sweep_start SHALL have priority over in_valid, and in_ready=0 in that cycle.
REQ-025 In SWEEP: busy=1, in_ready=0, sweep_start ignored; internal counter k starts at 0 and issues address k whenever the slot is free, then k increments.
REQ-026 SWEEP->DONE after address DEPTH-1 is issued and its result is handshaken (out_valid & out_ready).
REQ-027 DONE: done=1 for exactly one cycle, busy=0, in_ready=0; next state IDLE.
REQ-028 Writes during SWEEP SHALL affect only entries not yet issued.
REQ-029 The counter SHALL be W+1 bits wide so that k=DEPTH is not wrapped to 0 before termination.

Reset
REQ-030 rst=1 at clk edge SHALL force state IDLE, all table entries 0, k=0, out_valid=0, out_data=0, out_addr=0, busy=0, done=0.
REQ-031 rst SHALL override every other input in the same cycle, including mid-sweep and pending output; no done pulse is produced.
REQ-032 in_ready SHALL be 0 while rst=1.

Structure
REQ-033 Package lut_pkg SHALL hold the state encodings (IDLE, SWEEP, DONE) and the DEFAULT_W=4 constant.
REQ-034 The table SHALL be a sub-module lut_array (write port plus one combinational read port); the FSM, counter and output slot live in lut_sweep.

Verification
REQ-035 W=4: write table[5]=4'hA, then lookup in_data=5 with out_ready=1 -> out_valid=1, out_data=4'hA, out_addr=5 one cycle after the handshake.
REQ-036 Backpressure: out_ready=0 with a result pending, offer in_data=3 -> in_ready=0, out_data held; raise out_ready -> new request accepted the same cycle.
REQ-037 Program table[k]=~k for k=0..15, pulse sweep_start, out_ready=1 -> 16 results with out_addr 0..15 and out_data F..0, busy=1 throughout, done a single pulse after the 16th handshake, then IDLE.
REQ-038 Same-cycle write table[7]=4'h1 (old value 4'h9) and lookup of 7 -> out_data=4'h9; a following lookup of 7 -> 4'h1.
REQ-039 Assert rst at sweep k=6 -> next cycle busy=0, out_valid=0, done never pulses; a lookup of any address returns 0.
REQ-040 sweep_start asserted together with in_valid in IDLE -> in_ready=0, the sweep starts, and the lookup is accepted only after DONE.

Source files
------------

// File: rtl/lut_pkg.sv
// Shared definitions for the lookup-table sweep block.
//   DEFAULT_W : default word width (address and data) of lut_sweep
//   state_t   : control FSM state encodings (IDLE, SWEEP, DONE)
package lut_pkg;

  localparam int unsigned DEFAULT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/lut_array.sv
// Register-file lookup table: 2**W entries of W bits.
// Ports:
//   clk, rst          : clock, synchronous active-high reset (clears all entries)
//   wr_en/wr_addr/wr_data : single write port, takes effect at the clock edge
//   rd_addr -> rd_data    : combinational read port; returns the pre-write
//                           value when read and write hit the same entry
module lut_array #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_addr,
  input  logic [W-1:0] wr_data,
  input  logic [W-1:0] rd_addr,
  output logic [W-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << W;

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lut_sweep.sv
// Lookup table with a single-slot registered output and an automatic sweep.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data    : table write port, active in every state
//   in_valid/in_data/in_ready: lookup request handshake (IDLE only)
//   out_valid/out_data/out_addr/out_ready : result slot handshake
//   sweep_start              : begin reading every entry in address order
//   busy                     : sweep in progress
//   done                     : one-cycle pulse when the sweep completes
module lut_sweep
  import lut_pkg::*;
#(
  parameter int unsigned W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_addr,
  input  logic [W-1:0] wr_data,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic [W-1:0] out_addr,
  input  logic         out_ready,
  input  logic         sweep_start,
  output logic         busy,
  output logic         done
);

  localparam int unsigned DEPTH = 1 << W;

  // Sweep counter carries one extra bit so "all issued" (k == DEPTH) is distinct
  // from address 0.
  localparam logic [W:0] K_END = {1'b1, {W{1'b0}}};

  state_t       state, state_nx;
  logic [W:0]   k, k_nx;
  logic         slot_free;
  logic         load;
  logic [W-1:0] load_addr;
  logic [W-1:0] rd_data;
  logic         in_ready_c;

  lut_array #(.W(W)) u_array (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (load_addr),
    .rd_data (rd_data)
  );

  assign slot_free = !out_valid || out_ready;

  always_comb begin
    state_nx   = state;
    k_nx       = k;
    in_ready_c = 1'b0;
    load       = 1'b0;
    load_addr  = in_data;
    case (state)
      IDLE: begin
        if (sweep_start) begin
          state_nx = SWEEP;
          k_nx     = '0;
        end else begin
          in_ready_c = slot_free;
          load       = in_valid && slot_free;
        end
      end
      SWEEP: begin
        load_addr = k[W-1:0];
        if (k != K_END) begin
          if (slot_free) begin
            load = 1'b1;
            k_nx = k + (W+1)'(1);
          end
        end else if (out_valid && out_ready) begin
          // Once every address is issued the slot can only hold the last one.
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
        k_nx     = '0;
      end
      default: begin
        state_nx = IDLE;
        k_nx     = '0;
      end
    endcase
  end

  assign in_ready = in_ready_c && !rst;
  assign busy     = (state == SWEEP);
  assign done     = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k     <= '0;
    end else begin
      state <= state_nx;
      k     <= k_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= rd_data;
      out_addr  <= load_addr;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lut_sweep.sv
module tb_lut_sweep;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en;
  logic [W-1:0] wr_addr;
  logic [W-1:0] wr_data;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [W-1:0] out_addr;
  logic         out_ready;
  logic         sweep_start;
  logic         busy;
  logic         done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lut_sweep #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_addr    (out_addr),
    .out_ready   (out_ready),
    .sweep_start (sweep_start),
    .busy        (busy),
    .done        (done)
  );

  typedef struct {
    logic         we;
    logic [W-1:0] wa;
    logic [W-1:0] wd;
    logic         iv;
    logic [W-1:0] id;
    logic         ordy;
    logic         e_rdy;
    logic         e_ov;
    logic [W-1:0] e_od;
    logic [W-1:0] e_oa;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic quiet;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    in_valid = 1'b0; in_data = '0; sweep_start = 1'b0;
  endtask

  task automatic program_inv;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_addr = W'(i); wr_data = ~W'(i);
      step;
    end
    wr_en = 1'b0;
  endtask

  vec_t vt[12];

  initial begin
    int n, last, done_at, busy_low, found, cnt, early;

    vt[0]  = '{1'b1, 4'd5, 4'hA, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'h0, 4'd0};
    vt[1]  = '{1'b0, 4'd0, 4'h0, 1'b1, 4'd5, 1'b1, 1'b1, 1'b1, 4'hA, 4'd5};
    vt[2]  = '{1'b1, 4'd3, 4'h6, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'hA, 4'd5};
    vt[3]  = '{1'b0, 4'd0, 4'h0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 4'hA, 4'd5};
    vt[4]  = '{1'b0, 4'd0, 4'h0, 1'b1, 4'd3, 1'b1, 1'b1, 1'b1, 4'h6, 4'd3};
    vt[5]  = '{1'b1, 4'd7, 4'h9, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'h0, 4'd0};
    vt[6]  = '{1'b1, 4'd7, 4'h1, 1'b1, 4'd7, 1'b1, 1'b1, 1'b1, 4'h9, 4'd7};
    vt[7]  = '{1'b0, 4'd0, 4'h0, 1'b1, 4'd7, 1'b1, 1'b1, 1'b1, 4'h1, 4'd7};
    vt[8]  = '{1'b0, 4'd0, 4'h0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'h0, 4'd0};
    vt[9]  = '{1'b1, 4'd0, 4'hF, 1'b1, 4'd0, 1'b1, 1'b1, 1'b1, 4'h0, 4'd0};
    vt[10] = '{1'b0, 4'd0, 4'h0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b1, 4'hF, 4'd0};
    vt[11] = '{1'b0, 4'd0, 4'h0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'hF, 4'd0};

    // Reset state
    quiet; out_ready = 1'b0; rst = 1'b1;
    in_valid = 1'b1;
    step; step;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0; quiet;
    step;

    // Table-driven lookups, backpressure, same-cycle write/read
    for (int i = 0; i < 12; i++) begin
      wr_en = vt[i].we; wr_addr = vt[i].wa; wr_data = vt[i].wd;
      in_valid = vt[i].iv; in_data = vt[i].id; out_ready = vt[i].ordy;
      #1;
      chk($sformatf("v%0d_in_ready", i), in_ready, vt[i].e_rdy);
      step;
      chk($sformatf("v%0d_out_valid", i), out_valid, vt[i].e_ov);
      if (vt[i].e_ov) begin
        chk($sformatf("v%0d_out_data", i), out_data, vt[i].e_od);
        chk($sformatf("v%0d_out_addr", i), out_addr, vt[i].e_oa);
      end
    end
    quiet; out_ready = 1'b1;
    step;

    // Full sweep over table[k] = ~k
    program_inv;
    step;
    sweep_start = 1'b1;
    #1;
    chk("sweep_start_in_ready", in_ready, 0);
    step;
    sweep_start = 1'b0;
    n = 0; last = -1; done_at = -1; busy_low = 0;
    for (int c = 0; c < 60 && done_at < 0; c++) begin
      if (done) begin
        done_at = c;
      end else begin
        if (!busy) busy_low++;
        if (out_valid) begin
          chk($sformatf("sweep_addr%0d", n), out_addr, n);
          chk($sformatf("sweep_data%0d", n), out_data, (~n) & 4'hF);
          n++;
          last = c;
        end
        step;
      end
    end
    chk("sweep_count", n, 16);
    chk("sweep_busy_low", busy_low, 0);
    chk("sweep_done_latency", done_at - last, 1);
    chk("done_busy", busy, 0);
    step;
    chk("after_done_pulse", done, 0);
    chk("after_done_busy", busy, 0);
    chk("after_done_out_valid", out_valid, 0);

    // Reset in the middle of a sweep
    sweep_start = 1'b1;
    step;
    sweep_start = 1'b0;
    found = 0;
    for (int c = 0; c < 40 && found == 0; c++) begin
      if (out_valid && out_addr == 4'd5) found = 1;
      else step;
    end
    chk("reach_k6", found, 1);
    rst = 1'b1; in_valid = 1'b1; in_data = 4'd1;
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    step;
    rst = 1'b0; in_valid = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_done", done, 0);
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (done || busy) cnt++;
      step;
    end
    chk("mid_rst_no_done", cnt, 0);
    in_valid = 1'b1; in_data = 4'd9;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    step;
    in_valid = 1'b0;
    chk("post_rst_out_valid", out_valid, 1);
    chk("post_rst_out_data", out_data, 0);

    // sweep_start wins over a simultaneous lookup; the lookup waits for DONE
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 4'h5;
    step;
    wr_en = 1'b0;
    sweep_start = 1'b1; in_valid = 1'b1; in_data = 4'd2;
    #1;
    chk("prio_in_ready", in_ready, 0);
    step;
    sweep_start = 1'b0;
    early = 0; done_at = -1;
    for (int c = 0; c < 60 && done_at < 0; c++) begin
      #1;
      if (done) done_at = c;
      else if (in_ready) early++;
      step;
    end
    chk("prio_done_seen", done_at >= 0, 1);
    chk("prio_early_accept", early, 0);
    // now IDLE, the held request is offered again
    #1;
    chk("prio_accept_after_done", in_ready, 1);
    step;
    in_valid = 1'b0;
    chk("prio_out_valid", out_valid, 1);
    chk("prio_out_data", out_data, 4'h5);
    chk("prio_out_addr", out_addr, 4'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
